// File: rtl/tictactoe_game_fsm_if.sv
// Button pulses in, board/cursor/status out: the link between the game logic
// and its neighbours (button debouncer upstream, board renderer downstream).
interface tictactoe_game_fsm_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_place;
  logic        new_game;
  logic [1:0]  cursor_row;
  logic [1:0]  cursor_col;
  logic [9:0]  cursor_x;
  logic [9:0]  cursor_y;
  logic [17:0] board;
  logic        turn;
  logic [1:0]  game_state;
  logic [8:0]  win_mask;
  logic [3:0]  move_count;
  logic        bad_move;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_place, new_game,
    input  cursor_row, cursor_col, cursor_x, cursor_y, board, turn,
           game_state, win_mask, move_count, bad_move
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_place, new_game,
    output cursor_row, cursor_col, cursor_x, cursor_y, board, turn,
           game_state, win_mask, move_count, bad_move
  );
endinterface

// File: rtl/tictactoe_game_fsm.sv
// Tic-tac-toe game logic: cursor, board, turn and win/draw detection, driven by
// debounced one-cycle button pulses on the slow game clock.
module tictactoe_game_fsm #(
  parameter int X_CENTER0 = 300,
  parameter int Y_CENTER0 = 100,
  parameter int PITCH     = 150
) (
  input  logic                clk,
  input  logic                rst,
  tictactoe_game_fsm_if.slave bus
);

  typedef enum logic [2:0] {S_PLAY, S_CHECK, S_XWIN, S_OWIN, S_DRAW} state_e;

  localparam logic [1:0] MARK_NONE = 2'b00;
  localparam logic [1:0] MARK_X    = 2'b01;
  localparam logic [1:0] MARK_O    = 2'b10;
  localparam logic [1:0] GS_PLAY   = 2'b00;
  localparam logic [1:0] GS_XWIN   = 2'b01;
  localparam logic [1:0] GS_OWIN   = 2'b10;
  localparam logic [1:0] GS_DRAW   = 2'b11;

  localparam int LINES [8][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  state_e      state_q;
  logic [1:0]  row_q, col_q;
  logic [17:0] board_q;
  logic        turn_q;
  logic [1:0]  game_state_q;
  logic [8:0]  win_mask_q;
  logic [3:0]  move_count_q;
  logic        bad_move_q;

  logic [4:0]  cell_lsb;
  logic [8:0]  win_mask_d;
  logic [1:0]  win_mark_d;

  function automatic logic [1:0] line_owner(logic [17:0] b, int c0, int c1, int c2);
    logic [1:0] m;
    m = b[2*c0 +: 2];
    return (m != MARK_NONE && m == b[2*c1 +: 2] && m == b[2*c2 +: 2]) ? m : MARK_NONE;
  endfunction

  assign cell_lsb = 5'((3 * int'(row_q) + int'(col_q)) * 2);

  // Every completed line contributes to the mask, so a double win lights both.
  always_comb begin
    logic [1:0] owner;
    owner      = MARK_NONE;
    win_mask_d = '0;
    win_mark_d = MARK_NONE;
    for (int l = 0; l < 8; l++) begin
      owner = line_owner(board_q, LINES[l][0], LINES[l][1], LINES[l][2]);
      if (owner != MARK_NONE) begin
        win_mask_d[LINES[l][0]] = 1'b1;
        win_mask_d[LINES[l][1]] = 1'b1;
        win_mask_d[LINES[l][2]] = 1'b1;
        win_mark_d              = owner;
      end
    end
  end

  // NOTE: all state here is updated with <= so every register samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_PLAY;
      row_q        <= 2'd1;
      col_q        <= 2'd1;
      board_q      <= '0;
      turn_q       <= 1'b0;
      game_state_q <= GS_PLAY;
      win_mask_q   <= '0;
      move_count_q <= '0;
      bad_move_q   <= 1'b0;
    end else if (bus.new_game) begin
      state_q      <= S_PLAY;
      row_q        <= 2'd1;
      col_q        <= 2'd1;
      board_q      <= '0;
      turn_q       <= 1'b0;
      game_state_q <= GS_PLAY;
      win_mask_q   <= '0;
      move_count_q <= '0;
      bad_move_q   <= 1'b0;
    end else begin
      bad_move_q <= 1'b0;
      case (state_q)
        S_PLAY: begin
          if (bus.btn_place) begin
            if (board_q[cell_lsb +: 2] == MARK_NONE) begin
              board_q[cell_lsb +: 2] <= turn_q ? MARK_O : MARK_X;
              move_count_q           <= move_count_q + 4'd1;
              state_q                <= S_CHECK;
            end else begin
              bad_move_q <= 1'b1;
            end
          end else if (bus.btn_right) begin
            col_q <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
          end else if (bus.btn_left) begin
            col_q <= (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
          end else if (bus.btn_up) begin
            row_q <= (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
          end else if (bus.btn_down) begin
            row_q <= (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
          end
        end
        S_CHECK: begin
          if (win_mark_d != MARK_NONE) begin
            win_mask_q   <= win_mask_d;
            state_q      <= (win_mark_d == MARK_X) ? S_XWIN : S_OWIN;
            game_state_q <= (win_mark_d == MARK_X) ? GS_XWIN : GS_OWIN;
          end else if (move_count_q == 4'd9) begin
            state_q      <= S_DRAW;
            game_state_q <= GS_DRAW;
          end else begin
            turn_q  <= ~turn_q;
            state_q <= S_PLAY;
          end
        end
        default: ;  // terminal states hold everything until new_game
      endcase
    end
  end

  assign bus.cursor_row = row_q;
  assign bus.cursor_col = col_q;
  assign bus.cursor_x   = 10'(X_CENTER0 + PITCH * int'(col_q));
  assign bus.cursor_y   = 10'(Y_CENTER0 + PITCH * int'(row_q));
  assign bus.board      = board_q;
  assign bus.turn       = turn_q;
  assign bus.game_state = game_state_q;
  assign bus.win_mask   = win_mask_q;
  assign bus.move_count = move_count_q;
  assign bus.bad_move   = bad_move_q;

endmodule

// File: tb/tb_tictactoe_game_fsm.sv
// Scoreboard bench for tictactoe_game_fsm: a rule-level game model predicts the
// outputs after each clock edge; a separate monitor compares them.
module tb_tictactoe_game_fsm;

  typedef struct packed {
    logic [1:0]  row;
    logic [1:0]  col;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [17:0] board;
    logic        turn;
    logic [1:0]  gs;
    logic [8:0]  wm;
    logic [3:0]  mc;
    logic        bad;
  } snap_t;

  localparam int B_UP = 1, B_DOWN = 2, B_LEFT = 4, B_RIGHT = 8, B_PLACE = 16, B_NG = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tictactoe_game_fsm_if bus ();

  tictactoe_game_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  snap_t exp_q[$];

  // Reference model: the game as the rules describe it.
  int   cells[9];
  int   crow, ccol, mc, gs;
  bit   turn, bad, pending;
  bit [8:0] wm;
  int   lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic void model_reset();
    foreach (cells[i]) cells[i] = 0;
    crow = 1; ccol = 1; mc = 0; gs = 0;
    turn = 0; bad = 0; pending = 0; wm = '0;
  endfunction

  function automatic void model_step(int b);
    int winner;
    bit [8:0] acc;
    bad = 0;
    if ((b & B_NG) != 0) begin
      model_reset();
    end else if (pending) begin
      pending = 0;
      winner  = 0;
      acc     = '0;
      for (int l = 0; l < 8; l++) begin
        if (cells[lines[l][0]] != 0 && cells[lines[l][0]] == cells[lines[l][1]] &&
            cells[lines[l][0]] == cells[lines[l][2]]) begin
          winner = cells[lines[l][0]];
          for (int j = 0; j < 3; j++) acc[lines[l][j]] = 1'b1;
        end
      end
      if (winner != 0) begin
        wm = acc;
        gs = winner;          // 1 = X wins, 2 = O wins
      end else if (mc == 9) begin
        gs = 3;
      end else begin
        turn = !turn;
      end
    end else if (gs == 0) begin
      if ((b & B_PLACE) != 0) begin
        if (cells[crow*3 + ccol] == 0) begin
          cells[crow*3 + ccol] = turn ? 2 : 1;
          mc++;
          pending = 1;
        end else begin
          bad = 1;
        end
      end else if ((b & B_RIGHT) != 0) ccol = (ccol + 1) % 3;
      else if ((b & B_LEFT) != 0)      ccol = (ccol + 2) % 3;
      else if ((b & B_UP) != 0)        crow = (crow + 2) % 3;
      else if ((b & B_DOWN) != 0)      crow = (crow + 1) % 3;
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.row  = 2'(crow);
    s.col  = 2'(ccol);
    s.x    = 10'(300 + 150 * ccol);
    s.y    = 10'(100 + 150 * crow);
    s.board = '0;
    for (int k = 0; k < 9; k++) s.board[2*k +: 2] = 2'(cells[k]);
    s.turn = turn;
    s.gs   = 2'(gs);
    s.wm   = wm;
    s.mc   = 4'(mc);
    s.bad  = bad;
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.row   = bus.cursor_row;
    s.col   = bus.cursor_col;
    s.x     = bus.cursor_x;
    s.y     = bus.cursor_y;
    s.board = bus.board;
    s.turn  = bus.turn;
    s.gs    = bus.game_state;
    s.wm    = bus.win_mask;
    s.mc    = bus.move_count;
    s.bad   = bus.bad_move;
    return s;
  endfunction

  task automatic check(string name, snap_t act, snap_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got row=%0d col=%0d x=%0d y=%0d board=%h turn=%0d gs=%0d wm=%b mc=%0d bad=%0d; expected row=%0d col=%0d x=%0d y=%0d board=%h turn=%0d gs=%0d wm=%b mc=%0d bad=%0d",
               name, act.row, act.col, act.x, act.y, act.board, act.turn, act.gs, act.wm, act.mc, act.bad,
               exp.row, exp.col, exp.x, exp.y, exp.board, exp.turn, exp.gs, exp.wm, exp.mc, exp.bad);
    end
  endtask

  task automatic drive(int b);
    bus.btn_up    = b[0];
    bus.btn_down  = b[1];
    bus.btn_left  = b[2];
    bus.btn_right = b[3];
    bus.btn_place = b[4];
    bus.new_game  = b[5];
  endtask

  // One clock of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic step(int b);
    @(negedge clk);
    drive(b);
    model_step(b);
    exp_q.push_back(model_snap());
  endtask

  task automatic goto_cell(int k);
    while (ccol != k % 3) step(B_RIGHT);
    while (crow != k / 3) step(B_DOWN);
  endtask

  task automatic place_at(int k);
    goto_cell(k);
    step(B_PLACE);
    step(0);
  endtask

  task automatic play(int seq[$]);
    foreach (seq[i]) place_at(seq[i]);
  endtask

  // Monitor: compares the DUT just after each active edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle%0d", cycle), dut_snap(), e);
      end
    end
  end

  initial begin
    int r, b;
    drive(0);
    model_reset();
    repeat (2) @(negedge clk);
    check("reset", dut_snap(), model_snap());
    rst = 1'b0;

    // Cursor wrap in both axes
    step(B_RIGHT); step(B_RIGHT); step(B_UP); step(B_UP); step(B_LEFT); step(B_DOWN);

    // First mark, then a placement on the occupied centre
    step(B_NG);
    step(B_PLACE); step(0); step(B_PLACE); step(0);

    // X wins on the top row, then everything is frozen
    step(B_NG);
    play('{0, 3, 1, 4, 2});
    step(B_PLACE); step(B_RIGHT); step(B_DOWN); step(B_UP | B_LEFT); step(0);

    // Full board with no line
    step(B_NG);
    play('{0, 1, 2, 4, 7, 6, 3, 5, 8});
    step(B_PLACE); step(0);

    // place beats right; O wins; new_game from a win
    step(B_NG);
    step(B_PLACE | B_RIGHT); step(0);
    play('{0, 3, 1, 8, 2});
    step(B_NG); step(0);

    // Async reset while the winning placement is being evaluated
    play('{0, 3, 1, 4});
    goto_cell(2);
    step(B_PLACE);
    @(negedge clk);
    drive(0);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst", dut_snap(), model_snap());
    exp_q.push_back(model_snap());
    @(negedge clk);
    rst = 1'b0;

    // Random play with occasional restarts and simultaneous buttons
    repeat (2500) begin
      r = $urandom_range(0, 99);
      if (r < 2)       b = B_NG;
      else if (r < 30) b = B_PLACE;
      else             b = $urandom_range(0, 31);
      step(b);
    end
    step(0);
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tictactoe_game_fsm.md
Name: tictactoe_game_fsm

Overview:
Game-logic stage directly upstream of the board/cursor renderer. Consumes single-cycle, debounced button pulses and maintains:
- the 3x3 board
- cursor cell and whose turn it is
- win/draw status
It publishes cursor pixel centres and per-cell marks for the renderer, which draws the X/O sprites and cursor. It runs on the slow game clock that also drives the renderer's position logic.

Parameters:
X_CENTER0  300  hCount of column-0 cell centre
Y_CENTER0  100  vCount of row-0 cell centre
PITCH      150  pixel distance between adjacent cell centres

Ports:
clk         in   1   slow game clock
rst         in   1   asynchronous, active-high reset
btn_up      in   1   one-cycle pulse: cursor row-1
btn_down    in   1   one-cycle pulse: cursor row+1
btn_left    in   1   one-cycle pulse: cursor col-1
btn_right   in   1   one-cycle pulse: cursor col+1
btn_place   in   1   one-cycle pulse: place current player's mark at cursor
new_game    in   1   one-cycle pulse: clear board, restart
cursor_row  out  2   0..2
cursor_col  out  2   0..2
cursor_x    out  10  X_CENTER0 + cursor_col*PITCH (combinational from cursor_col)
cursor_y    out  10  Y_CENTER0 + cursor_row*PITCH (combinational from cursor_row)
board       out  18  cell k = row*3+col occupies bits [2k+1:2k]; 00 empty, 01 X, 10 O
turn        out  1   0 = X to move, 1 = O to move
game_state  out  2   00 PLAY, 01 X_WIN, 10 O_WIN, 11 DRAW
win_mask    out  9   bit k set if cell k is on a winning line
move_count  out  4   marks placed, 0..9
bad_move    out  1   one-cycle pulse: place attempted on an occupied cell

Behaviour:
- Reset (async) and new_game (sync) produce the same state:
  - cursor (1,1), so cursor_x=450, cursor_y=250
  - board=0, turn=0, game_state=PLAY, win_mask=0, move_count=0, bad_move=0
  - internal FSM = S_PLAY
- new_game has priority over every other input in every FSM state.
- FSM states: S_PLAY, S_CHECK, S_XWIN, S_OWIN, S_DRAW.
- game_state encoding: PLAY in S_PLAY and S_CHECK; X_WIN in S_XWIN; O_WIN in S_OWIN; DRAW in S_DRAW.
- S_PLAY input priority, one action per cycle: place > right > left > up > down.
  - Place on an empty cell:
    - write mark (01 if turn=0, else 10) into the cell
    - move_count+1
    - go to S_CHECK
    - all at the next edge
  - Place on an occupied cell: board unchanged, bad_move=1 for one cycle, stay in S_PLAY.
  - Cursor moves wrap modulo 3: col 2 + right -> 0; col 0 + left -> 2; row 0 + up -> 2; row 2 + down -> 0.
- S_CHECK, exactly one cycle:
  - Evaluate 8 lines (3 rows, 3 cols, 2 diagonals) on the registered board.
  - If any line has three equal non-empty marks: set win_mask to the OR of all winning lines (a double win shows both). Go to S_XWIN if the mark is 01, S_OWIN if 10.
  - Else if move_count==9: go to S_DRAW.
  - Else: toggle turn, go to S_PLAY.
  - All button inputs except new_game are ignored in this state.
- S_XWIN / S_OWIN / S_DRAW:
  - Terminal. Board, cursor, turn and win_mask are frozen; all buttons except new_game are ignored.
  - turn keeps the winner's value.
- Latency: place pulse sampled at edge N -> board/move_count updated at N; game_state/turn/win_mask final at N+1. A cursor move is visible on cursor_x/y right after the sampling edge.
- Reset mid-S_CHECK discards the pending evaluation; everything returns to reset values.
- Width rules:
  - cursor_x/y computed in 10 bits; max values 600/400 with defaults; no overflow.
  - move_count saturates logically at 9 (cannot exceed, since S_PLAY is left at 9).

Test Plan:
- Reset, then 2 right pulses -> cursor_col 2 then 0 (wrap), cursor_x 600 then 300; 1 up from row 1 -> row 0, cursor_y 100; 1 more up -> row 2, cursor_y 400.
- Place at (1,1) -> board bits[9:8]=01, move_count=1, next cycle turn=1, game_state=PLAY; place again at (1,1) -> bad_move pulses once, board unchanged, turn stays 1.
- X plays cells 0,1,2 while O plays 3,4 -> after X's third place plus 1 cycle: game_state=01, win_mask=9'b000000111; further places/moves leave board and cursor unchanged.
- Draw sequence X:0,2,3,7,8 with O:1,4,5,6 -> after the 9th place plus 1 cycle: game_state=11, move_count=9, win_mask=0.
- place and right asserted in the same cycle at (1,1) -> mark written at (1,1), cursor stays col 1; new_game in S_OWIN -> full reset state (cursor 450/250, board 0, turn 0) on the next edge.
- Assert rst asynchronously one cycle after a winning place, i.e. in S_CHECK -> outputs reach reset values immediately without a clock edge; game_state stays PLAY, win_mask=0.
